// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB3 round-robin arbiter.
package apb_arb_pkg;

    // Bus-side transfer phase
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam int unsigned NUM_REQ         = 2;

endpackage

// File: rtl/apb_rr_pick.sv
// Two-way round-robin picker: one-hot grant, favouring the requester not granted last.
module apb_rr_pick
    import apb_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               last_i,
    output logic [NUM_REQ-1:0] gnt_c_o
);

    // Single request wins outright; contention goes to the other side of last_i
    always_comb begin
        gnt_c_o = '0;
        case (req_i)
            2'b01:   gnt_c_o = 2'b01;
            2'b10:   gnt_c_o = 2'b10;
            2'b11:   gnt_c_o = last_i ? 2'b01 : 2'b10;
            default: gnt_c_o = '0;
        endcase
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Two requesters share one APB3 master port; round-robin grant, wait-state timeout.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  write0,
    input  logic                  write1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  err0,
    output logic                  err1,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  penable,
    output logic                  psel1,
    output logic                  psel2,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    apb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    req_m;
    logic [NUM_REQ-1:0]    gnt_c;
    logic                  last_q, last_d;     // 1: requester 1 was granted last
    logic                  own_q, own_d;       // requester owning the current transfer
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic                  done_ok;
    logic                  timeout_hit;

    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  penable_q, penable_d;
    logic                  psel1_q, psel1_d;
    logic                  psel2_q, psel2_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  err0_q, err0_d;
    logic                  err1_q, err1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    // A requester being acked this cycle sits out arbitration
    assign req_m = {req1 & ~ack1_q, req0 & ~ack0_q};

    apb_rr_pick u_pick (
        .req_i   (req_m),
        .last_i  (last_q),
        .gnt_c_o (gnt_c)
    );

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign done_ok     = (state_q == ST_ACCESS) && pready;
    assign timeout_hit = (state_q == ST_ACCESS) && !pready && (cnt_inc == CNT_W'(TIMEOUT));

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: grant -> one SETUP cycle -> ACCESS until ready or timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|gnt_c) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (done_ok || timeout_hit) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: latch fields at grant, report status at completion
    always_comb begin
        last_d   = last_q;
        own_d    = own_q;
        cnt_d    = cnt_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = err0_q;
        err1_d   = err1_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (|gnt_c) begin
                    own_d    = gnt_c[1];
                    last_d   = gnt_c[1];
                    cnt_d    = '0;
                    pwrite_d = gnt_c[1] ? write1 : write0;
                    paddr_d  = gnt_c[1] ? addr1  : addr0;
                    pwdata_d = gnt_c[1] ? wdata1 : wdata0;
                end
            end
            ST_ACCESS: begin
                if (done_ok) begin
                    if (own_q) begin
                        ack1_d = 1'b1;
                        err1_d = pslverr;
                        if (!pwrite_q) rdata1_d = prdata;
                    end else begin
                        ack0_d = 1'b1;
                        err0_d = pslverr;
                        if (!pwrite_q) rdata0_d = prdata;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        if (own_q) begin
                            ack1_d = 1'b1;
                            err1_d = 1'b1;
                        end else begin
                            ack0_d = 1'b1;
                            err0_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase

        penable_d = (state_d == ST_ACCESS);
        psel1_d   = (state_d != ST_IDLE) && !paddr_d[ADDR_WIDTH-1];
        psel2_d   = (state_d != ST_IDLE) &&  paddr_d[ADDR_WIDTH-1];
    end

    // Output and datapath registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            last_q    <= 1'b1;
            own_q     <= 1'b0;
            cnt_q     <= '0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            penable_q <= 1'b0;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            last_q    <= last_d;
            own_q     <= own_d;
            cnt_q     <= cnt_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            penable_q <= penable_d;
            psel1_q   <= psel1_d;
            psel2_q   <= psel2_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign penable = penable_q;
    assign psel1   = psel1_q;
    assign psel2   = psel2_q;
    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule
